// File: rtl/nn_fifo_pkg.sv
// nn_fifo_pkg: shared read-controller state type and FIFO geometry defaults for the wishbone_nn datapath
package nn_fifo_pkg;
   localparam int FIFO_DATA_W = 32;
   localparam int FIFO_DEPTH = 8;
   typedef enum logic [1:0] {IDLE, BURST, LAST} rd_state_t;
endpackage

// File: rtl/fifo_level_tracker.sv
// fifo_level_tracker: bounded up/down shadow of FIFO occupancy
module fifo_level_tracker
   import nn_fifo_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int LEN_W = $clog2(DEPTH) + 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [LEN_W-1:0] level,
   output logic             empty
);
   always_ff @(posedge clk) begin
      if (rst) level <= '0;
      else if (inc && level < LEN_W'(DEPTH)) level <= level + 1'b1;
      else if (dec && level != '0) level <= level - 1'b1;
   end
   assign empty = level == '0;
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: arbitrates FIFO writes against pops and drains words onto a valid/ready stream in bursts
module fifo_burst_reader
   import nn_fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int LEN_W = $clog2(DEPTH) + 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   output logic              wr_ack,
   input  logic              fifo_full,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_ce,
   output logic              fifo_we,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              flush,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [LEN_W-1:0]  level,
   output logic              empty
);
   rd_state_t state;
   logic [LEN_W-1:0] remaining, eff_len;
   logic flush_pend, pop, go_full, go_flush;
   assign eff_len = (burst_len == '0 || burst_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : burst_len;
   assign wr_ack = wr_req && !fifo_full && !rst;
   // a pending write owns the shared ce/we slot even when the FIFO refuses it
   assign pop = !rst && state == BURST && !wr_req && remaining != '0 && (!m_valid || m_ready) && !empty;
   assign fifo_we = wr_ack;
   assign fifo_ce = wr_ack || pop;
   assign go_full = level >= eff_len;
   assign go_flush = flush_pend && !empty;
   fifo_level_tracker #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_level (
      .clk(clk), .rst(rst), .inc(wr_ack), .dec(pop), .level(level), .empty(empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         remaining <= '0;
         flush_pend <= 1'b0;
         m_valid <= 1'b0;
         m_last <= 1'b0;
         m_data <= '0;
      end else begin
         if (pop) begin
            m_data <= fifo_data;
            m_valid <= 1'b1;
            m_last <= remaining == LEN_W'(1);
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last <= 1'b0;
         end
         // in IDLE a pending flush either starts a burst or finds nothing to drain
         flush_pend <= flush || (flush_pend && state != IDLE);
         case (state)
            IDLE:
               if (go_full) begin
                  state <= BURST;
                  remaining <= eff_len;
               end else if (go_flush) begin
                  state <= BURST;
                  remaining <= level;
               end
            BURST:
               if (pop) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == LEN_W'(1)) state <= LAST;
               end
            LAST: if (m_valid && m_ready && m_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and random checks against a FIFO model and an in-order word scoreboard
module tb_fifo_burst_reader;
   import nn_fifo_pkg::*;
   localparam int DW = 32;
   localparam int DEPTH = 8;
   localparam int LW = 4;
   logic clk = 0, rst = 1, wr_req = 0, flush = 0, m_ready = 1;
   logic fifo_full, fifo_ce, fifo_we, wr_ack, m_valid, m_last, empty;
   logic [DW-1:0] data_i = '0, fifo_data, m_data;
   logic [LW-1:0] burst_len = 4, level;
   logic [DW-1:0] mem [DEPTH];
   int wp = 0, rp = 0, cnt = 0;
   int tests = 0, fails = 0, cyc = 0;
   logic [DW-1:0] exp_q[$], got_d[$];
   logic got_l[$];
   int got_t[$];
   logic pv = 0, pl = 0;
   logic [DW-1:0] pd = '0;
   int cw;
   logic [DW-1:0] hold;

   always #5 clk = ~clk;

   fifo_burst_reader dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_ack(wr_ack), .fifo_full(fifo_full),
      .fifo_data(fifo_data), .fifo_ce(fifo_ce), .fifo_we(fifo_we), .burst_len(burst_len),
      .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .level(level), .empty(empty)
   );

   assign fifo_full = cnt == DEPTH;
   assign fifo_data = mem[rp];
   always @(posedge clk) begin
      if (rst) begin
         wp <= 0; rp <= 0; cnt <= 0;
      end else if (fifo_ce && fifo_we && cnt < DEPTH) begin
         mem[wp] <= data_i; wp <= (wp + 1) % DEPTH; cnt <= cnt + 1;
      end else if (fifo_ce && !fifo_we && cnt > 0) begin
         rp <= (rp + 1) % DEPTH; cnt <= cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic acc;
      #1;
      if (pv) begin
         chk("bp_valid", 32'(m_valid), 32'(1'b1));
         chk("bp_data", m_data, pd);
         chk("bp_last", 32'(m_last), 32'(pl));
      end
      acc = wr_req && cnt < DEPTH && !rst;
      chk("wr_ack", 32'(wr_ack), 32'(acc));
      chk("fifo_we", 32'(fifo_we), 32'(acc));
      if (wr_req) chk("no_pop_on_wr", 32'(fifo_ce && !fifo_we), 32'(1'b0));
      if (rst) chk("ce_in_rst", 32'(fifo_ce), 32'(1'b0));
      else begin
         chk("level", 32'(level), 32'(cnt));
         chk("empty", 32'(empty), 32'(cnt == 0));
      end
      if (m_valid && m_ready && !rst) begin
         got_d.push_back(m_data); got_l.push_back(m_last); got_t.push_back(cyc);
         chk("word_expected", 32'(exp_q.size() != 0), 32'(1'b1));
         if (exp_q.size() != 0) chk("order", m_data, exp_q.pop_front());
      end
      pv = m_valid && !m_ready && !rst;
      pd = m_data; pl = m_last;
      if (acc) exp_q.push_back(data_i);
      if (rst) exp_q.delete();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic clr();
      got_d.delete(); got_l.delete(); got_t.delete();
   endtask

   task automatic write_words(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wr_req = 1; data_i = base + DW'(i);
         tick();
      end
      wr_req = 0;
   endtask

   task automatic wait_hs(input int n, input int bound);
      for (int k = 0; k < bound && got_d.size() < n; k++) tick();
      chk("hs_count", 32'(got_d.size()), 32'(n));
   endtask

   task automatic drain();
      m_ready = 1; wr_req = 0;
      for (int k = 0; k < 300 && (exp_q.size() != 0 || cnt != 0 || m_valid); k++) begin
         flush = (k % 16) == 4;
         tick();
      end
      flush = 0;
      tick();
      chk("drain_done", 32'(exp_q.size()), 32'(0));
      chk("drain_level", 32'(level), 32'(0));
   endtask

   initial begin
      wr_req = 1; data_i = 32'hDEAD;
      tick(); tick();
      rst = 0; wr_req = 0;
      #1;
      chk("rst_valid", 32'(m_valid), 32'(1'b0));
      chk("rst_last", 32'(m_last), 32'(1'b0));
      chk("rst_data", m_data, 32'h0);
      chk("rst_level", 32'(level), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1'b1));
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      chk("rst_flush_pend", 32'(dut.flush_pend), 32'(1'b0));

      clr(); burst_len = 4;
      write_words(32'hA0, 4);
      cw = cyc;
      chk("t1_level4", 32'(level), 32'(4));
      wait_hs(4, 30);
      for (int i = 0; i < 4 && i < got_d.size(); i++) begin
         chk("t1_data", got_d[i], 32'hA0 + DW'(i));
         chk("t1_last", 32'(got_l[i]), 32'(i == 3));
         chk("t1_consec", 32'(got_t[i]), 32'(got_t[0] + i));
      end
      if (got_t.size() > 0) chk("t1_latency", 32'(got_t[0]), 32'(cw + 2));
      tick(); tick();
      chk("t1_level0", 32'(level), 32'(0));
      chk("t1_state", 32'(dut.state), 32'(IDLE));

      clr(); burst_len = 8;
      write_words(32'hB0, 3);
      tick(); tick();
      chk("t2_no_start", 32'(m_valid), 32'(1'b0));
      flush = 1; tick(); flush = 0;
      wait_hs(3, 30);
      for (int i = 0; i < 3 && i < got_d.size(); i++) begin
         chk("t2_data", got_d[i], 32'hB0 + DW'(i));
         chk("t2_last", 32'(got_l[i]), 32'(i == 2));
      end
      tick(); tick();
      chk("t2_flush_pend", 32'(dut.flush_pend), 32'(1'b0));
      chk("t2_state", 32'(dut.state), 32'(IDLE));

      clr(); burst_len = 0;
      for (int i = 0; i < 10; i++) begin
         wr_req = 1; data_i = 32'hC0 + DW'(i);
         #1;
         chk("t3_ack", 32'(wr_ack), 32'(i < 8));
         if (i >= 8) begin
            chk("t3_ce_refused", 32'(fifo_ce), 32'(1'b0));
            chk("t3_full", 32'(fifo_full), 32'(1'b1));
            chk("t3_level8", 32'(level), 32'(8));
         end
         tick();
      end
      wr_req = 0;
      wait_hs(8, 40);
      for (int i = 0; i < 8 && i < got_d.size(); i++) begin
         chk("t3_data", got_d[i], 32'hC0 + DW'(i));
         chk("t3_last", 32'(got_l[i]), 32'(i == 7));
      end
      tick(); tick();

      clr(); burst_len = 8;
      write_words(32'hD0, 8);
      for (int i = 0; i < 6; i++) begin
         wr_req = (i % 2) == 0; data_i = 32'hE0 + DW'(i);
         tick();
      end
      wr_req = 0; m_ready = 0;
      #1;
      chk("t4_valid_at_stall", 32'(m_valid), 32'(1'b1));
      hold = m_data;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_hold", m_data, hold);
         chk("t4_no_pop", 32'(fifo_ce), 32'(1'b0));
         tick();
      end
      drain();
      chk("t4_count", 32'(got_d.size()), 32'(10));
      if (got_d.size() >= 8) begin
         chk("t4_last_word", got_d[7], 32'hD7);
         chk("t4_last_flag", 32'(got_l[7]), 32'(1'b1));
         chk("t4_mid_flag", 32'(got_l[3]), 32'(1'b0));
      end

      clr(); burst_len = 6;
      write_words(32'hF0, 6);
      wait_hs(2, 30);
      rst = 1; tick(); rst = 0;
      #1;
      chk("t5_state", 32'(dut.state), 32'(IDLE));
      chk("t5_valid", 32'(m_valid), 32'(1'b0));
      chk("t5_level", 32'(level), 32'(0));
      clr(); burst_len = 4;
      write_words(32'h60, 4);
      wait_hs(4, 30);
      for (int i = 0; i < 4 && i < got_d.size(); i++) begin
         chk("t5_data", got_d[i], 32'h60 + DW'(i));
         chk("t5_last", 32'(got_l[i]), 32'(i == 3));
      end
      tick(); tick();

      for (int i = 0; i < 400; i++) begin
         wr_req = $urandom_range(0, 9) < 4;
         data_i = $urandom;
         m_ready = $urandom_range(0, 9) < 7;
         flush = $urandom_range(0, 19) == 0;
         burst_len = LW'($urandom_range(0, 15));
         tick();
      end
      flush = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the 8-entry `fifo_buffer` in the wishbone_nn datapath. Owns the FIFO's shared `ce`/`we` strobes, arbitrating producer writes against its own pops. Keeps a shadow occupancy count, since the FIFO exposes only `full`. Drains stored words onto a valid/ready output stream in bursts of a programmed length, with an explicit flush for partial bursts.

## Interface
- `DATA_W`, 32: FIFO word width. Must equal the FIFO's `FIFO_TYPE`.
- `DEPTH`, 8: FIFO entries. Must equal the FIFO's `FIFO_SPACES`.
- `LEN_W`, `$clog2(DEPTH)+1`: width of the level and burst-length fields.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset. Must be the same net as the FIFO's `rst`.
- `wr_req`  in  1  producer wants to write `data_i` into the FIFO this cycle.
- `wr_ack`  out  1  the write is accepted this cycle.
- `fifo_full`  in  1  the FIFO's `full` output.
- `fifo_data`  in  DATA_W  the FIFO's `data_o`, valid combinationally while `fifo_ce=1`.
- `fifo_ce`  out  DATA_W-independent, 1 bit  drives the FIFO's `ce`.
- `fifo_we`  out  1  drives the FIFO's `we`.
- `burst_len`  in  LEN_W  words per burst. 0, or any value >DEPTH, means DEPTH. Sampled on burst start.
- `flush`  in  1  one-cycle pulse requesting that a partial burst be drained.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_W  output word.
- `m_last`  out  1  marks the final word of a burst.
- `level`  out  LEN_W  shadow occupancy, 0..DEPTH.
- `empty`  out  1  `level==0`.

## Operation
- **Write arbitration**
  - `wr_ack = wr_req & ~fifo_full & ~rst`.
  - `fifo_we = wr_ack`.
  - `fifo_ce = wr_ack | pop`.
  - `wr_req` with `fifo_full` high drives `ce=0`. This prevents the FIFO from treating the request as a pop.
- **Pop rule:** `pop = (state==BURST) & ~wr_req & (remaining>0) & (~m_valid | m_ready) & (level>0)`.
  - Writes always win the slot.
  - A pop never coincides with `wr_req`, even when that write is refused because the FIFO is full.
- **Level:** +1 on `wr_ack`, −1 on `pop`. The two never occur in the same cycle. `level` must never exceed DEPTH or go below 0.
- **Output register:** on `pop`, `m_data<=fifo_data`, `m_valid<=1`, and `m_last<=(remaining==1)`. Otherwise, on `m_valid & m_ready`, `m_valid<=0` and `m_last<=0`.
- **`flush_pend`:** set by `flush`. Cleared on entry to BURST, or in IDLE when `level==0`.
- **FSM** (states IDLE, BURST, LAST):
  - **IDLE → BURST** when `level>=eff_len`: set `remaining=eff_len`, where `eff_len` is the clamped `burst_len`.
  - **IDLE → BURST** when `flush_pend & level>0`: set `remaining=level`.
  - **BURST:** pops decrement `remaining`. When the pop with `remaining==1` occurs, go to LAST.
  - **LAST:** wait for the `m_last` handshake (`m_valid & m_ready & m_last`), then go to IDLE.
- `flush` asserted during BURST or LAST is held pending and serviced after returning to IDLE.

## Timing
- **Reset values:** `m_valid=0`, `m_last=0`, `m_data=0`, `level=0`, `empty=1`, state=IDLE, `flush_pend=0`.
- **Outputs forced low while `rst` is high:** `fifo_ce=0`, `fifo_we=0`, `wr_ack=0`.
- **Burst start:** the IDLE→BURST decision is registered, so the first pop occurs in the cycle after the qualifying level or flush. The first `m_valid` is high the cycle after that pop.
- **Throughput:** with `m_ready=1` and no `wr_req`, the block sustains one word per cycle. A burst of N words shows `m_valid` for N consecutive cycles.
- **Write stalls:** each `wr_req` cycle inside a burst stalls a pop by exactly one cycle.
- **Backpressure:** `m_data` and `m_last` hold stable while `m_valid & ~m_ready`.
- **Reset mid-burst:** the burst is abandoned. Words already popped are lost. `level` returns to 0 together with the FIFO.
- **Wrap-around:** handled by the FIFO. The block never relies on FIFO addresses.

## Structure
- Package `nn_fifo_pkg` holds:
  - the `rd_state_t` enum (IDLE, BURST, LAST);
  - the default `DATA_W` and `DEPTH` localparams shared with `fifo_buffer`.
- Sub-module `fifo_level_tracker` contains the saturating-checked up/down shadow counter and produces `level` and `empty`.
- All other logic sits in the top block.

## Test plan
- **Full burst:** with `burst_len=4`, write 4 words (0xA0..0xA3) with `m_ready=1`. Expect outputs 0xA0..0xA3 on 4 consecutive cycles, `m_last` only on 0xA3, and `level` 4→0.
- **Flush:** write 3 words with `burst_len=8`, then pulse `flush`. Expect 3 words, `m_last` on the third, and `flush_pend` cleared.
- **Full FIFO:** hold `wr_req` for 10 cycles with no burst. Expect `wr_ack` for 8 cycles then 0, `fifo_ce=0` on refused cycles, and `level=8`, `full`.
- **Write collision and backpressure:**
  - During a DEPTH burst, assert `wr_req` on alternate cycles. Expect pops only on non-`wr_req` cycles, no lost or duplicated words, and `level` consistent.
  - Deassert `m_ready` for 3 cycles mid-burst. Expect `m_data` stable and no pops until a handshake.
- **Reset mid-burst:** assert `rst` after 2 words of a 6-word burst. Next cycle: state IDLE, `m_valid=0`, `level=0`. A subsequent 4-word write triggers a normal burst.
